// File: rtl/mc_datapath.sv
// Multicycle MIPS datapath: PC/IR/MDR/A/B/ALUOut, 32x32 register file, ALU and funct decode.
// All sequencing comes from the external multicycle controller; there is no internal FSM.
module mc_datapath #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        PCWrite,
   input  logic        PCWriteCond,
   input  logic        IorD,
   input  logic        r_wbar,
   input  logic        IRWrite,
   input  logic        memToReg,
   input  logic        RegWrite,
   input  logic        RegDst,
   input  logic        aluSrcA,
   input  logic [1:0]  aluSrcB,
   input  logic [1:0]  aluop,
   input  logic [1:0]  PCSrc,
   output logic [5:0]  opCode,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic        mem_we,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [2:0] {
      AluAdd,
      AluSub,
      AluAnd,
      AluOr,
      AluSlt
   } alu_op_e;

   logic [31:0] pc_q;
   logic [31:0] ir_q;
   logic [31:0] mdr_q;
   logic [31:0] a_q;
   logic [31:0] b_q;
   logic [31:0] alu_out_q;
   logic [31:0] rf_q [32];

   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  wr_addr;
   logic [31:0] wr_data;
   logic [31:0] rs_data;
   logic [31:0] rt_data;
   logic [31:0] imm_sext;
   logic [31:0] alu_a;
   logic [31:0] alu_b;
   logic [31:0] alu_res;
   logic [31:0] jump_target;
   logic [31:0] pc_next;
   logic        zero;
   logic        pc_en;
   alu_op_e     alu_op;
   logic [4:0]  unused_shamt;

   assign rs           = ir_q[25:21];
   assign rt           = ir_q[20:16];
   assign rd           = ir_q[15:11];
   assign unused_shamt = ir_q[10:6];
   assign opCode       = ir_q[31:26];
   assign imm_sext     = {{16{ir_q[15]}}, ir_q[15:0]};
   assign jump_target  = {pc_q[31:28], ir_q[25:0], 2'b00};

   // Register 0 is hardwired to zero on the read side.
   assign rs_data = (rs == 5'd0) ? 32'd0 : rf_q[rs];
   assign rt_data = (rt == 5'd0) ? 32'd0 : rf_q[rt];
   assign wr_addr = RegDst ? rd : rt;
   assign wr_data = memToReg ? mdr_q : alu_out_q;

   assign mem_addr  = IorD ? alu_out_q : pc_q;
   assign mem_wdata = b_q;
   assign mem_we    = ~r_wbar & ~reset;

   always_comb begin
      alu_a = aluSrcA ? a_q : pc_q;
      unique case (aluSrcB)
         2'b00:   alu_b = b_q;
         2'b01:   alu_b = 32'd4;
         2'b10:   alu_b = imm_sext;
         default: alu_b = {imm_sext[29:0], 2'b00};
      endcase
   end

   always_comb begin
      alu_op = AluAdd;
      unique case (aluop)
         2'b01: alu_op = AluSub;
         2'b10: begin
            unique case (ir_q[5:0])
               6'b100010: alu_op = AluSub;
               6'b100100: alu_op = AluAnd;
               6'b100101: alu_op = AluOr;
               6'b101010: alu_op = AluSlt;
               default:   alu_op = AluAdd;
            endcase
         end
         default: alu_op = AluAdd;
      endcase
   end

   always_comb begin
      alu_res = 32'd0;
      unique case (alu_op)
         AluSub:  alu_res = alu_a - alu_b;
         AluAnd:  alu_res = alu_a & alu_b;
         AluOr:   alu_res = alu_a | alu_b;
         AluSlt:  alu_res = ($signed(alu_a) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_res = alu_a + alu_b;
      endcase
   end

   assign zero  = (alu_res == 32'd0);
   assign pc_en = PCWrite | (PCWriteCond & zero);

   always_comb begin
      unique case (PCSrc)
         2'b01:   pc_next = alu_out_q;
         2'b10:   pc_next = jump_target;
         default: pc_next = alu_res;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q      <= RESET_PC;
         ir_q      <= 32'd0;
         mdr_q     <= 32'd0;
         a_q       <= 32'd0;
         b_q       <= 32'd0;
         alu_out_q <= 32'd0;
         for (int i = 0; i < 32; i++) begin
            rf_q[i] <= 32'd0;
         end
      end else begin
         a_q       <= rs_data;
         b_q       <= rt_data;
         mdr_q     <= mem_rdata;
         alu_out_q <= alu_res;
         if (IRWrite) begin
            ir_q <= mem_rdata;
         end
         if (pc_en) begin
            pc_q <= pc_next;
         end
         if (RegWrite && (wr_addr != 5'd0)) begin
            rf_q[wr_addr] <= wr_data;
         end
      end
   end

endmodule

// File: doc/mc_datapath.md
# mc_datapath

Multicycle MIPS datapath that executes under the multicycle controller FSM. It holds PC, IR, MDR, A, B, ALUOut and the 32×32 register file. It also contains the ALU and ALU-control decode, and drives the single unified instruction/data memory port. It returns `opCode` (IR[31:26]) to the controller, which steps it through fetch, decode, address, memory, execute, writeback, branch and jump states.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000, PC value loaded on reset.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high.
- `PCWrite`  in  1  unconditional PC load.
- `PCWriteCond`  in  1  PC load when ALU zero = 1.
- `IorD`  in  1  memory address select: 0 = PC, 1 = ALUOut.
- `r_wbar`  in  1  1 = read, 0 = write memory.
- `IRWrite`  in  1  load IR from `mem_rdata`.
- `memToReg`  in  1  register write data: 0 = ALUOut, 1 = MDR.
- `RegWrite`  in  1  register file write enable.
- `RegDst`  in  1  destination: 0 = rt (IR[20:16]), 1 = rd (IR[15:11]).
- `aluSrcA`  in  1  0 = PC, 1 = A.
- `aluSrcB`  in  2  00 = B, 01 = 32'd4, 10 = signext(imm16), 11 = signext(imm16)<<2.
- `aluop`  in  2  00 = add, 01 = sub, 10 = decode funct, 11 = add.
- `PCSrc`  in  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = ALU result.
- `opCode`  out  6  IR[31:26].
- `mem_addr`  out  32  memory byte address.
- `mem_wdata`  out  32  store data (= B).
- `mem_we`  out  1  memory write strobe.
- `mem_rdata`  in  32  memory read data, combinational w.r.t. `mem_addr`.

## Operation
- Funct decode for aluop = 10:
  - 100000 add; 100010 sub; 100100 and; 100101 or.
  - 101010 slt: signed compare, result 32'd1 or 32'd0.
  - Any other funct: add.
- All ALU arithmetic is 32-bit with wrap, no overflow trap.
- `zero` = (ALU result == 0). Internal only; it gates `PCWriteCond`.
- Jump target = {PC[31:28], IR[25:0], 2'b00}, using the current PC.
- `mem_addr` = IorD ? ALUOut : PC.
- `mem_we` = ~r_wbar & ~reset, combinational. The memory commits a write on the rising edge while `mem_we` = 1.
- Register file:
  - Two combinational read ports addressed by IR[25:21] (rs) and IR[20:16] (rt).
  - One write port, write data selected by `memToReg`.
  - Register 0 always reads 0; writes to it are discarded.
- Registers loaded every cycle: A ← rs data, B ← rt data, MDR ← `mem_rdata`, ALUOut ← ALU result.
- IR ← `mem_rdata` only when IRWrite = 1.
- PC ← PCSrc mux output when PCWrite | (PCWriteCond & zero).
- No internal FSM. Sequencing comes entirely from the control inputs. The block makes no assumption about which combinations are legal.

## Timing
- Reset is synchronous. On a clock edge with reset = 1:
  - PC = RESET_PC.
  - IR, A, B, MDR, ALUOut = 0.
  - All 32 registers = 0.
  - Reset overrides PCWrite, IRWrite and RegWrite in the same cycle.
- Output values while in reset:
  - `opCode` = 0.
  - `mem_we` = 0 while reset is high.
  - `mem_addr` = PC (or ALUOut) per IorD, after the first reset edge.
- Fetch: in the IF cycle, `mem_addr` = PC. IR and PC+4 are captured on the same edge, so `opCode` is valid in the next (ID) cycle.
- Decode: A and B reflect the new IR one edge after IR loads. ALUOut captures the branch target in ID, using IR as loaded.
- Register write and same-cycle read of the same register: A and B capture the old value; the new value is visible one cycle later.
- Load: MDR is valid the cycle after the memory-read cycle, for use in writeback.
- Branch: `zero` is evaluated from the current A and B in the branch cycle. PC updates on that edge.
- Reset asserted mid-instruction: state is cleared on that edge. Execution resumes from RESET_PC with no residual writes.

## Test plan
1. **Reset:** hold reset 2 cycles with PCWrite = RegWrite = IRWrite = 1 and r_wbar = 0. Required: PC = 0, `opCode` = 0, `mem_we` = 0 throughout, all registers read 0.
2. **Fetch:** `mem_rdata` = 32'h8C22_0004 (lw $2,4($1)) with the IF control set. Required: next cycle `opCode` = 6'd35 and PC = 4.
3. **Load / add / store:**
   - Memory word @4 = 5 and @8 = 7.
   - lw $1,4($0); lw $2,8($0); add $3,$1,$2 (32'h0022_1820); sw $3,12($0).
   - Required: on the store cycle, `mem_addr` = 12, `mem_wdata` = 12, `mem_we` = 1.
4. **Branch:** beq with imm = 3 at PC = 0x10.
   - A == B: PC = 0x20.
   - A != B: PC stays 0x14 (already PC+4).
5. **Jump:** 32'h0800_0010 fetched at PC = 0x10. Required: PC = 0x40 after the jump-completion cycle.
6. **slt and $0:**
   - slt with $1 = 32'hFFFF_FFFF, $2 = 1 writes 1.
   - A write to $0 of 32'hDEAD_BEEF still reads 0.
